// File: rtl/theta_stage_if.sv
// Stream bundle for theta_stage: slice input stream plus indexed slice output stream.
interface theta_stage_if #(
  parameter int unsigned IDX_W = 6
);
  logic             in_valid;
  logic             in_ready;
  logic [24:0]      in_slice;
  logic             out_valid;
  logic             out_ready;
  logic [24:0]      out_slice;
  logic [IDX_W-1:0] out_index;

  modport slave (
    input  in_valid, in_slice, out_ready,
    output in_ready, out_valid, out_slice, out_index
  );

  modport master (
    output in_valid, in_slice, out_ready,
    input  in_ready, out_valid, out_slice, out_index
  );
endinterface

// File: rtl/theta_stage.sv
// Column-parity mixing stage: buffers a full frame of 5x5 slices, then emits each slice
// mixed with its own and its predecessor's column parity. Optional macro: THETA_BYPASS_EN.
module theta_stage #(
  parameter int unsigned NSLICE = 64,
  parameter int unsigned IDX_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  theta_stage_if.slave      bus,
`ifdef THETA_BYPASS_EN
  input  logic              bypass,
`endif
  output logic              busy,
  output logic              done
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  typedef enum logic [1:0] {S_LOAD, S_EMIT, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [24:0]      r_mem [NSLICE];
  logic [4:0]       r_par [NSLICE];

  logic [IDX_W-1:0] r_cnt;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [24:0]      r_out_slice;
  logic [IDX_W-1:0] r_out_index;
  logic             r_busy;
  logic             r_done;

  logic             w_in_fire;
  logic             w_out_fire;
  logic             w_last_in;
  logic             w_last_out;
  logic [4:0]       w_in_par;
  logic [IDX_W-1:0] w_next_idx;

  logic [IDX_W-1:0] w_cnt_d;
  logic             w_in_ready_d;
  logic             w_out_valid_d;
  logic [24:0]      w_out_slice_d;
  logic [IDX_W-1:0] w_out_index_d;
  logic             w_busy_d;
  logic             w_done_d;
  logic             w_bypass;

  function automatic logic [4:0] col_parity(input logic [24:0] a);
    logic [4:0] c;
    c = '0;
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        c[x] = c[x] ^ a[5*y + x];
    return c;
  endfunction

  // a ^ C[z][x-1] ^ C[z-1][x+1], column indices mod 5
  function automatic logic [24:0] theta_mix(input logic [24:0] a, input logic [4:0] cz,
                                            input logic [4:0] cp);
    logic [24:0] r;
    r = '0;
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        r[5*y + x] = a[5*y + x] ^ cz[(x + 4) % 5] ^ cp[(x + 1) % 5];
    return r;
  endfunction

`ifdef THETA_BYPASS_EN
  assign w_bypass = bypass;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_in_fire  = bus.in_valid && r_in_ready;
  assign w_out_fire = r_out_valid && bus.out_ready;
  assign w_last_in  = w_in_fire && (r_cnt == LAST_IDX);
  assign w_last_out = w_out_fire && (r_out_index == LAST_IDX);
  assign w_in_par   = col_parity(bus.in_slice);
  assign w_next_idx = r_out_index + IDX_W'(1);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_LOAD;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_LOAD:  if (w_last_in)  w_state_nxt = S_EMIT;
      S_EMIT:  if (w_last_out) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_LOAD;
      default: w_state_nxt = S_LOAD;
    endcase
  end

  // Next values of the registered outputs; slice 0 uses the parity of the slice arriving now
  always_comb begin
    w_cnt_d       = w_in_fire ? r_cnt + IDX_W'(1) : r_cnt;
    w_in_ready_d  = (w_state_nxt == S_LOAD);
    w_out_valid_d = (w_state_nxt == S_EMIT);
    w_done_d      = (w_state_nxt == S_DONE);
    w_busy_d      = (w_state_nxt != S_LOAD) || (w_cnt_d != '0);
    w_out_slice_d = r_out_slice;
    w_out_index_d = r_out_index;
    if (r_state == S_LOAD && w_last_in) begin
      w_out_index_d = '0;
      w_out_slice_d = w_bypass ? r_mem[0] : theta_mix(r_mem[0], r_par[0], w_in_par);
    end else if (r_state == S_EMIT && w_out_fire && !w_last_out) begin
      w_out_index_d = w_next_idx;
      w_out_slice_d = w_bypass ? r_mem[w_next_idx]
                               : theta_mix(r_mem[w_next_idx], r_par[w_next_idx],
                                           r_par[r_out_index]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_slice <= '0;
      r_out_index <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_cnt       <= w_cnt_d;
      r_in_ready  <= w_in_ready_d;
      r_out_valid <= w_out_valid_d;
      r_out_slice <= w_out_slice_d;
      r_out_index <= w_out_index_d;
      r_busy      <= w_busy_d;
      r_done      <= w_done_d;
    end
  end

  // Frame storage is deliberately not reset
  always_ff @(posedge clk) begin
    if (!rst && w_in_fire) begin
      r_mem[r_cnt] <= bus.in_slice;
      r_par[r_cnt] <= w_in_par;
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_slice = r_out_slice;
  assign bus.out_index = r_out_index;
  assign busy          = r_busy;
  assign done          = r_done;

endmodule

// File: tb/tb_theta_stage.sv
// Scoreboard bench for theta_stage: directed frames, expected slices queued at issue time.
module tb_theta_stage;
  localparam int unsigned NSLICE = 64;
  localparam int unsigned IDX_W  = 6;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [24:0]      sl;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  logic done;
`ifdef THETA_BYPASS_EN
  logic bypass;
`endif

  always #5 clk = ~clk;

  theta_stage_if #(.IDX_W(IDX_W)) bus ();

  theta_stage #(.NSLICE(NSLICE), .IDX_W(IDX_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
`ifdef THETA_BYPASS_EN
    .bypass(bypass),
`endif
    .busy  (busy),
    .done  (done)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  int          done_cnt = 0;
  int          ready_mode = 0;
  int          cyc = 0;
  exp_t        q[$];
  logic [24:0] frame [NSLICE];
  logic [24:0] expv  [NSLICE];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual %h required %h", name, act, req);
    end
  endtask

  // out_ready pattern: mode 0 always high, mode 1 repeating 1,0,0
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 0) bus.out_ready = 1'b1;
      else                 bus.out_ready = (cyc % 3 == 0);
      cyc++;
    end
  end

  // Monitor: pops the scoreboard on each output handshake, checks stall stability
  initial begin
    logic        stalled;
    logic [24:0] st_slice;
    logic [IDX_W-1:0] st_idx;
    exp_t        e;
    stalled = 1'b0;
    st_slice = '0;
    st_idx = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stalled = 1'b0;
      end else begin
        if (done) done_cnt++;
        if (stalled) begin
          chk("stall_valid", 32'(bus.out_valid), 32'd1);
          chk("stall_slice", 32'(bus.out_slice), 32'(st_slice));
          chk("stall_index", 32'(bus.out_index), 32'(st_idx));
        end
        stalled = 1'b0;
        if (bus.out_valid) begin
          chk("in_ready_emit", 32'(bus.in_ready), 32'd0);
          if (bus.out_ready) begin
            if (q.size() == 0) begin
              n_cmp++;
              n_bad++;
              $display("FAIL unexpected_output: actual idx %0d slice %h required none",
                       bus.out_index, bus.out_slice);
            end else begin
              e = q.pop_front();
              chk("out_slice", 32'(bus.out_slice), 32'(e.sl));
              chk("out_index", 32'(bus.out_index), 32'(e.idx));
            end
          end else begin
            stalled  = 1'b1;
            st_slice = bus.out_slice;
            st_idx   = bus.out_index;
          end
        end
      end
    end
  end

  task automatic clear_frame();
    for (int i = 0; i < int'(NSLICE); i++) begin
      frame[i] = '0;
      expv[i]  = '0;
    end
  endtask

  task automatic push_expected();
    exp_t e;
    for (int i = 0; i < int'(NSLICE); i++) begin
      e.idx = IDX_W'(i);
      e.sl  = expv[i];
      q.push_back(e);
    end
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_out_slice"}, 32'(bus.out_slice), 32'd0);
    chk({tag, "_out_index"}, 32'(bus.out_index), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
  endtask

  // Feeds n slices of frame[]; called at posedge+1
  task automatic load_slices(input int n, output bit ok);
    int t;
    ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      bus.in_valid = 1'b1;
      bus.in_slice = frame[i];
      t = 0;
      @(negedge clk);
      while (!bus.in_ready && t < 200) begin
        @(negedge clk);
        t++;
      end
      if (t >= 200) begin
        n_cmp++;
        n_bad++;
        $display("FAIL in_ready_timeout: actual 0 required 1 at slice %0d", i);
        ok = 1'b0;
        bus.in_valid = 1'b0;
        return;
      end
      if (i == n - 1) chk("valid_before_last", 32'(bus.out_valid), 32'd0);
      if (i == 1) chk("busy_loading", 32'(busy), 32'd1);
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    bus.in_slice = '0;
  endtask

  task automatic run_frame(input string tag);
    bit ok;
    int t;
    int d0;
    d0 = done_cnt;
    push_expected();
    load_slices(int'(NSLICE), ok);
    if (!ok) return;
    chk({tag, "_first_valid_lat"}, 32'(bus.out_valid), 32'd1);
    t = 0;
    while ((q.size() != 0 || done_cnt == d0) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_drain_timeout: actual %0d left required 0", tag, q.size());
      q.delete();
    end
    repeat (4) @(negedge clk);
    chk({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
    chk({tag, "_busy_idle"}, 32'(busy), 32'd0);
    chk({tag, "_in_ready_idle"}, 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_slice = '0;
`ifdef THETA_BYPASS_EN
    bypass = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_state("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // all-zero frame
    clear_frame();
    run_frame("zeros");

    // single bit in slice 0, column 0
    clear_frame();
    frame[0] = 25'h0000001;
    expv[0]  = 25'h0210843;
    expv[1]  = 25'h1084210;
    run_frame("slice0");

    // wrap: slice 63 feeds slice 0
    clear_frame();
    frame[63] = 25'h0000001;
    expv[63]  = 25'h0210843;
    expv[0]   = 25'h1084210;
    run_frame("wrap");

    // bit x=4,y=4 in slice 5
    clear_frame();
    frame[5] = 25'h1000000;
    expv[5]  = 25'h1108421;
    expv[6]  = 25'h0842108;
    run_frame("x4y4");

    // back-pressure 1,0,0
    clear_frame();
    frame[0] = 25'h0000001;
    expv[0]  = 25'h0210843;
    expv[1]  = 25'h1084210;
    ready_mode = 1;
    run_frame("stall");
    ready_mode = 0;

    // reset after partial load, then a fresh frame
    clear_frame();
    for (int i = 0; i < 10; i++) frame[i] = 25'h1555555;
    load_slices(10, ok);
    rst = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_state("midrst");
    @(posedge clk);
    #1;
    clear_frame();
    frame[0] = 25'h0000001;
    expv[0]  = 25'h0210843;
    expv[1]  = 25'h1084210;
    run_frame("postrst");

`ifdef THETA_BYPASS_EN
    clear_frame();
    frame[0]  = 25'h0000001;
    frame[17] = 25'h1555555;
    frame[63] = 25'h0ABCDEF;
    expv[0]   = 25'h0000001;
    expv[17]  = 25'h1555555;
    expv[63]  = 25'h0ABCDEF;
    bypass = 1'b1;
    run_frame("bypass");
    bypass = 1'b0;
    clear_frame();
    frame[0] = 25'h0000001;
    expv[0]  = 25'h0210843;
    expv[1]  = 25'h1084210;
    run_frame("nobypass");
`endif

    repeat (3) @(negedge clk);
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
